// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline RAW-hazard stall, redirect flush, debug halt/step and perf counters
module pipeline_hazard_ctrl #(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       e_rw,
    input  logic             e_regwr,
    input  logic [4:0]       m_rw,
    input  logic             m_regwr,
    input  logic [4:0]       w_rw,
    input  logic             w_regwe,
    input  logic             pcsrc,
    input  logic             dbg_halt,
    input  logic             dbg_step,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       advance;
    logic       hazard;
    logic       stall;
    logic       rs_hit;
    logic       rt_hit;

    // Register 0 is hardwired zero, so a writer to $0 never creates a dependency.
    function automatic logic src_hit(input logic [4:0] src, input logic use_src,
                                     input logic [4:0] er, input logic ew,
                                     input logic [4:0] mr, input logic mw,
                                     input logic [4:0] wr, input logic ww);
        logic hit;
        hit = ((src == er) && ew) || ((src == mr) && mw);
        if (WB_BYPASS == 0) begin
            hit = hit || ((src == wr) && ww);
        end
        return use_src && (src != 5'd0) && hit;
    endfunction

    always_comb begin
        rs_hit  = src_hit(id_rs, id_use_rs, e_rw, e_regwr, m_rw, m_regwr, w_rw, w_regwe);
        rt_hit  = src_hit(id_rt, id_use_rt, e_rw, e_regwr, m_rw, m_regwr, w_rw, w_regwe);
        hazard  = rs_hit || rt_hit;
        advance = (state == ST_RUN) || (state == ST_STEP);
        stall   = !pcsrc && advance && hazard;
        halted  = (state == ST_HALTED);
    end

    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        if (pcsrc) begin
            // Redirect overrides everything: the ID instruction is wrong-path, so its hazard is moot.
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (stall) begin
            id_ex_bubble = 1'b1;
        end else if (advance) begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
        end else begin
            id_ex_bubble = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (dbg_halt) state_nxt = ST_HALTED;
            ST_HALTED: begin
                if (dbg_step) begin
                    state_nxt = ST_STEP;
                end else if (!dbg_halt) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_STEP:   state_nxt = dbg_halt ? ST_HALTED : ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (pcsrc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
